// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: command and FSM state encodings shared by the SPI RAM burst block
package spi_ram_pkg;
  typedef enum logic [1:0] {WR_ADDR = 2'b00, WR_DATA = 2'b01, RD_ADDR = 2'b10, RD_DATA = 2'b11} cmd_t;
  typedef enum logic [1:0] {IDLE = 2'b00, READ = 2'b01, HOLD = 2'b10} state_t;
endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: synchronous single-port word array with an optional output register
module spi_ram_mem #(
  parameter int DATA_W = 8,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] q;
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) q <= mem[addr];
  end
  // q only changes on a read, so the free-running second stage also holds its value
  if (RD_LAT == 2) begin : g_oreg
    logic [DATA_W-1:0] r;
    always_ff @(posedge clk) r <= q;
    assign rdata = r;
  end else begin : g_noreg
    assign rdata = q;
  end
endmodule

// File: rtl/spi_ram_burst.sv
// spi_ram_burst: command-driven RAM with pointer registers, burst auto-increment and held read data
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MEM_DEPTH = 256,
  parameter int RD_LAT = 1,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  input  logic              tx_ack,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              busy,
  output logic              drop_err
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_DEPTH - 1);
  state_t state, state_n;
  cmd_t cmd;
  logic acc, seen;
  logic [ADDR_W-1:0] wp, rp;
  logic [DATA_W-1:0] rdata;
  assign cmd = cmd_t'(din[DATA_W+1:DATA_W]);
  assign acc = rx_valid && state == IDLE;
  assign busy = state != IDLE;
  assign tx_valid = state == HOLD;
  // dout reads zero after reset until the first read completes
  assign dout = seen ? rdata : '0;
  always_comb begin
    state_n = state == IDLE ? (acc && cmd == RD_DATA ? (RD_LAT == 1 ? HOLD : READ) : IDLE)
            : state == READ ? HOLD
            : tx_ack ? IDLE : HOLD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      seen <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state <= state_n;
      seen <= seen | (state_n == HOLD);
      drop_err <= drop_err | (rx_valid && busy);
      if (acc && cmd == WR_ADDR) wp <= din[ADDR_W-1:0];
      else if (acc && cmd == WR_DATA && AUTO_INC != 0) wp <= wp == LAST ? '0 : wp + ADDR_W'(1);
      if (acc && cmd == RD_ADDR) rp <= din[ADDR_W-1:0];
      else if (acc && cmd == RD_DATA && AUTO_INC != 0) rp <= rp == LAST ? '0 : rp + ADDR_W'(1);
    end
  end
  spi_ram_mem #(.DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_mem (
    .clk(clk),
    .we(acc && cmd == WR_DATA),
    .re(acc && cmd == RD_DATA),
    .addr(cmd == WR_DATA ? wp : rp),
    .wdata(din[DATA_W-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_spi_ram_burst.sv
// tb_spi_ram_burst: directed checks of an RD_LAT=1 auto-increment instance and an RD_LAT=2 fixed-pointer instance
module tb_spi_ram_burst;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rv1 = 1'b0, ack1 = 1'b0, rv2 = 1'b0, ack2 = 1'b0;
  logic [9:0] d1 = '0, d2 = '0;
  logic [7:0] dout1, dout2;
  logic txv1, busy1, drop1, txv2, busy2, drop2;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  spi_ram_burst dut1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rv1), .din(d1), .tx_ack(ack1),
    .dout(dout1), .tx_valid(txv1), .busy(busy1), .drop_err(drop1)
  );
  spi_ram_burst #(.RD_LAT(2), .AUTO_INC(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rv2), .din(d2), .tx_ack(ack2),
    .dout(dout2), .tx_valid(txv2), .busy(busy2), .drop_err(drop2)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cmd1(input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    rv1 = 1'b1;
    d1 = {c, p};
    @(negedge clk);
    rv1 = 1'b0;
  endtask
  task automatic cmd2(input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    rv2 = 1'b1;
    d2 = {c, p};
    @(negedge clk);
    rv2 = 1'b0;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_txv", txv1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_drop", drop1, 0);
    chk("rst_dout", dout1, 0);
    chk("rst_txv2", txv2, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", busy1, 0);
    // basic write then read back, consumer always ready
    ack1 = 1'b1;
    cmd1(2'b00, 8'h10);
    cmd1(2'b01, 8'hA5);
    cmd1(2'b10, 8'h10);
    cmd1(2'b11, 8'h00);
    chk("basic_txv", txv1, 1);
    chk("basic_dout", dout1, 8'hA5);
    chk("basic_busy", busy1, 1);
    @(negedge clk);
    chk("basic_txv_fall", txv1, 0);
    chk("basic_idle", busy1, 0);
    chk("basic_dout_hold", dout1, 8'hA5);
    chk("basic_nodrop", drop1, 0);
    // pointer wrap at the top of the address space
    cmd1(2'b00, 8'hFF);
    cmd1(2'b01, 8'h11);
    cmd1(2'b01, 8'h22);
    cmd1(2'b10, 8'hFF);
    cmd1(2'b11, 8'h00);
    chk("wrap_rd0", dout1, 8'h11);
    @(negedge clk);
    cmd1(2'b11, 8'h00);
    chk("wrap_rd1", dout1, 8'h22);
    @(negedge clk);
    // stall in HOLD with a write attempted that must be dropped
    ack1 = 1'b0;
    cmd1(2'b00, 8'h10);
    cmd1(2'b10, 8'h10);
    cmd1(2'b11, 8'h00);
    for (int i = 0; i < 5; i++) begin
      chk("stall_txv", txv1, 1);
      chk("stall_dout", dout1, 8'hA5);
      if (i == 1) begin
        rv1 = 1'b1;
        d1 = {2'b01, 8'h77};
      end
      @(negedge clk);
      rv1 = 1'b0;
    end
    chk("stall_drop", drop1, 1);
    chk("stall_still_hold", txv1, 1);
    // read command coinciding with the ack is not accepted
    ack1 = 1'b1;
    rv1 = 1'b1;
    d1 = {2'b11, 8'h00};
    @(negedge clk);
    rv1 = 1'b0;
    chk("ack_rd_txv", txv1, 0);
    chk("ack_rd_busy", busy1, 0);
    cmd1(2'b10, 8'h10);
    cmd1(2'b11, 8'h00);
    chk("drop_no_write", dout1, 8'hA5);
    @(negedge clk);
    cmd1(2'b01, 8'h33);
    cmd1(2'b10, 8'h10);
    cmd1(2'b11, 8'h00);
    chk("drop_wp_kept", dout1, 8'h33);
    @(negedge clk);
    chk("drop_sticky", drop1, 1);
    // two-cycle latency instance, pointers fixed
    ack2 = 1'b0;
    cmd2(2'b00, 8'h20);
    cmd2(2'b01, 8'hC3);
    cmd2(2'b01, 8'h3C);
    cmd2(2'b10, 8'h20);
    cmd2(2'b11, 8'h00);
    chk("lat2_busy_n1", busy2, 1);
    chk("lat2_txv_n1", txv2, 0);
    @(negedge clk);
    chk("lat2_txv_n2", txv2, 1);
    chk("lat2_dout", dout2, 8'h3C);
    ack2 = 1'b1;
    @(negedge clk);
    chk("lat2_txv_fall", txv2, 0);
    cmd2(2'b11, 8'h00);
    chk("lat2_again_txv", txv2, 0);
    @(negedge clk);
    chk("lat2_noinc_dout", dout2, 8'h3C);
    @(negedge clk);
    chk("lat2_drop", drop2, 0);
    // reset while holding read data
    ack1 = 1'b0;
    cmd1(2'b10, 8'h10);
    cmd1(2'b11, 8'h00);
    chk("pre_rst_hold", txv1, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_txv", txv1, 0);
    chk("arst_busy", busy1, 0);
    chk("arst_drop", drop1, 0);
    chk("arst_dout", dout1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_abandon", txv1, 0);
    ack1 = 1'b1;
    cmd1(2'b11, 8'h00);
    chk("arst_rp0", dout1, 8'h22);
    @(negedge clk);
    cmd1(2'b10, 8'h10);
    cmd1(2'b11, 8'h00);
    chk("arst_mem_kept", dout1, 8'h33);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
